// File: rtl/digital_lock_system.sv
// digital_lock_system: single-password lock with wrong-entry counting and timed alarm lockout
module digital_lock_system #(
    parameter logic [3:0] PASSWORD       = 4'b1010,
    parameter int         MAX_TRIES      = 3,
    parameter int         LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] code,
    input  logic       code_valid,
    output logic       unlock,
    output logic       alarm,
    output logic [1:0] fail_count
);
    typedef enum logic [1:0] {LOCKED, OPEN, LOCKOUT} state_t;
    state_t     state, state_nx;
    logic [7:0] timer, timer_nx;
    logic [1:0] fail_nx;
    logic [2:0] miss_cnt;
    logic       match;
    assign match    = code == PASSWORD;
    assign miss_cnt = {1'b0, fail_count} + 3'd1;
    always_comb begin
        state_nx = state;
        fail_nx  = fail_count;
        timer_nx = timer;
        case (state)
            LOCKED, OPEN: begin
                if (code_valid && match) begin
                    state_nx = OPEN;
                    fail_nx  = 2'd0;
                end else if (code_valid && miss_cnt >= 3'(MAX_TRIES)) begin
                    state_nx = LOCKOUT;
                    fail_nx  = 2'(MAX_TRIES);
                    timer_nx = 8'(LOCKOUT_CYCLES - 1);
                end else if (code_valid) begin
                    state_nx = LOCKED;
                    fail_nx  = miss_cnt[1:0];
                end
            end
            LOCKOUT: begin
                state_nx = timer == 8'd0 ? LOCKED : LOCKOUT;
                fail_nx  = timer == 8'd0 ? 2'd0 : fail_count;
                timer_nx = timer == 8'd0 ? 8'd0 : timer - 8'd1;
            end
            default: begin
                state_nx = LOCKED;
                fail_nx  = 2'd0;
                timer_nx = 8'd0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= LOCKED;
            timer      <= 8'd0;
            fail_count <= 2'd0;
            unlock     <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            fail_count <= fail_nx;
            unlock     <= state_nx == OPEN;
            alarm      <= state_nx == LOCKOUT;
        end
    end
endmodule

// File: tb/tb_digital_lock_system.sv
// tb_digital_lock_system: directed vectors with a queued scoreboard checked by a separate monitor
module tb_digital_lock_system;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] code = 4'b0000;
    logic       code_valid = 1'b0;
    logic       unlock, alarm;
    logic [1:0] fail_count;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    typedef struct {
        int         at;
        logic       u;
        logic       a;
        logic [1:0] f;
        string      nm;
    } exp_t;
    exp_t sb[$];

    digital_lock_system dut (
        .clk(clk), .reset_n(reset_n), .code(code), .code_valid(code_valid),
        .unlock(unlock), .alarm(alarm), .fail_count(fail_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.at != cyc || unlock !== e.u || alarm !== e.a || fail_count !== e.f) begin
                errors++;
                $display("FAIL %s: got unlock=%b alarm=%b fail_count=%0d, expected unlock=%b alarm=%b fail_count=%0d (cycle %0d/%0d)",
                         e.nm, unlock, alarm, fail_count, e.u, e.a, e.f, cyc, e.at);
            end
        end
        if (cyc > 0) begin
            checks++;
            if (unlock === 1'b1 && alarm === 1'b1) begin
                errors++;
                $display("FAIL exclusive: got unlock=1 alarm=1, expected not both set (cycle %0d)", cyc);
            end
        end
    end

    task automatic step(input logic rn, input logic v, input logic [3:0] c,
                        input logic eu, input logic ea, input logic [1:0] ef, input string nm);
        exp_t e;
        @(negedge clk);
        reset_n    = rn;
        code_valid = v;
        code       = c;
        e.at = cyc + 1;
        e.u  = eu;
        e.a  = ea;
        e.f  = ef;
        e.nm = nm;
        sb.push_back(e);
    endtask

    initial begin
        step(0, 0, 4'b0000, 0, 0, 0, "reset1");
        step(0, 0, 4'b0000, 0, 0, 0, "reset2");
        step(1, 1, 4'b1100, 0, 0, 1, "wrong");
        step(1, 1, 4'b1010, 1, 0, 0, "correct");
        step(1, 0, 4'b0101, 1, 0, 0, "hold_open1");
        step(1, 0, 4'b0011, 1, 0, 0, "hold_open2");
        step(1, 1, 4'b1010, 1, 0, 0, "open_rematch");
        step(1, 1, 4'b0011, 0, 0, 1, "relock");
        step(0, 0, 4'b0000, 0, 0, 0, "reset3");
        step(1, 1, 4'b0001, 0, 0, 1, "miss1");
        step(1, 1, 4'b0010, 0, 0, 2, "miss2");
        step(1, 1, 4'b0100, 0, 1, 3, "lockout_enter");
        step(1, 1, 4'b1010, 0, 1, 3, "lockout_ignore");
        for (int i = 0; i < 14; i++) step(1, 0, 4'b0000, 0, 1, 3, "lockout_hold");
        step(1, 0, 4'b0000, 0, 0, 0, "lockout_exit");
        step(1, 1, 4'b1010, 1, 0, 0, "post_unlock");
        step(0, 1, 4'b1010, 0, 0, 0, "rst_open");
        step(1, 1, 4'b1011, 0, 0, 1, "partial1");
        step(1, 1, 4'b0010, 0, 0, 2, "partial2");
        step(1, 1, 4'b1110, 0, 1, 3, "lockout2");
        step(1, 0, 4'b0000, 0, 1, 3, "lockout2_hold");
        step(1, 0, 4'b0000, 0, 1, 3, "lockout2_hold");
        step(0, 1, 4'b1010, 0, 0, 0, "rst_lockout");
        step(1, 0, 4'b0000, 0, 0, 0, "after_rst");
        step(1, 1, 4'b1010, 1, 0, 0, "after_rst_unlock");
        step(1, 0, 4'b0000, 1, 0, 0, "final_hold");
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/digital_lock_system.md
Name: digital_lock_system

Overview:
- Single-password electronic lock controller.
- Accepts 4-bit code entries, compares each against a fixed password, and drives a registered unlock output.
- Counts consecutive wrong entries and, after too many, enters a timed lockout with an alarm flag.
- Sits between a keypad/entry front-end and the actuator driver.

Parameters:
- PASSWORD, 4'b1010, code that opens the lock.
- MAX_TRIES, 3, consecutive wrong entries that trigger lockout (legal range 1..3).
- LOCKOUT_CYCLES, 16, clock cycles spent in lockout (legal range 1..255).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  synchronous active-low reset.
- code  input  4  entered code.
- code_valid  input  1  one-cycle strobe: code is sampled as an entry when high.
- unlock  output  1  1 = lock open (registered).
- alarm  output  1  1 = lockout active (registered).
- fail_count  output  2  current count of consecutive wrong entries (registered).

Behaviour:
- Interface: one clock domain; reset is synchronous and active-low.
- Reset:
  - When reset_n=0 at a rising edge: state=LOCKED, unlock=0, alarm=0, fail_count=0, lockout timer=0.
  - Reset has priority over all other inputs, including mid-lockout and mid-open.
- All outputs are registered. Each output reflects the state register; it changes on the edge that samples the causing input (1-cycle latency from strobe to output).
- code is ignored whenever code_valid=0.
- State LOCKED (unlock=0, alarm=0):
  - code_valid & code==PASSWORD -> OPEN; fail_count<=0.
  - code_valid & mismatch & fail_count+1 < MAX_TRIES -> stay LOCKED; fail_count<=fail_count+1.
  - code_valid & mismatch & fail_count+1 == MAX_TRIES -> LOCKOUT; fail_count<=MAX_TRIES; timer<=LOCKOUT_CYCLES-1.
- State OPEN (unlock=1, alarm=0):
  - code_valid & match -> stay OPEN; fail_count stays 0.
  - code_valid & mismatch -> LOCKED; fail_count<=1. If MAX_TRIES==1, go to LOCKOUT instead, per the LOCKED mismatch rule.
  - No strobe -> hold OPEN indefinitely.
- State LOCKOUT (unlock=0, alarm=1):
  - code_valid is ignored entirely, including a correct code.
  - timer decrements each cycle.
  - When timer==0 at an edge -> LOCKED; fail_count<=0; alarm<=0.
  - Lockout therefore lasts exactly LOCKOUT_CYCLES cycles of alarm=1.
- The comparison is a full 4-bit equality; there are no partial matches.
- fail_count saturates at MAX_TRIES and never wraps.
- unlock and alarm are never both 1.

Test Plan:
- Reset check: reset_n=0 for 2 cycles with code=4'b0000 -> unlock=0, alarm=0, fail_count=0.
- Wrong code: reset_n=1, strobe code=4'b1100 -> next cycle unlock=0, fail_count=1.
- Correct code: strobe code=4'b1010 -> next cycle unlock=1, fail_count=0. Code then changes with code_valid=0 -> unlock stays 1.
- Relock: in OPEN, strobe code=4'b0011 -> next cycle unlock=0, fail_count=1.
- Lockout: from LOCKED with fail_count=0, strobe 4'b0001, 4'b0010, 4'b0100 -> after the third strobe alarm=1, fail_count=3. A strobed 4'b1010 during lockout leaves unlock=0. Exactly 16 cycles later alarm=0 and fail_count=0; strobe 4'b1010 -> unlock=1.
- Reset priority: in OPEN, or mid-lockout, drive reset_n=0 with code_valid=1 and code=4'b1010 -> next cycle unlock=0, alarm=0, fail_count=0.
